// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_scheduler
// Function : Debounces the 11 keys, picks the last-pressed key, and hands the
//            tone generator a new half-period only at waveform boundaries.
// Revision : 1.0
// ============================================================================
module note_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] keys,
  input  logic        gen_ready,
  output logic [11:0] half_period,
  output logic        load,
  output logic [3:0]  note_idx,
  output logic [3:0]  active_count,
  output logic        conflict
);

  localparam logic [7:0] c_db_limit = DEBOUNCE_CYCLES[7:0];
  localparam logic [3:0] c_none     = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_PENDING = 2'd2
  } state_t;

  function automatic logic [11:0] half_of(input logic [3:0] idx);
    case (idx)
      4'd0:    half_of = 12'd2025;
      4'd1:    half_of = 12'd2145;
      4'd2:    half_of = 12'd2273;
      4'd3:    half_of = 12'd2408;
      4'd4:    half_of = 12'd2551;
      4'd5:    half_of = 12'd2703;
      4'd6:    half_of = 12'd2864;
      4'd7:    half_of = 12'd3034;
      4'd8:    half_of = 12'd3214;
      4'd9:    half_of = 12'd3405;
      4'd10:   half_of = 12'd3608;
      default: half_of = 12'd0;
    endcase
  endfunction

  function automatic logic [3:0] lowest_set(input logic [10:0] v);
    lowest_set = c_none;
    for (int i = 10; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  function automatic logic [3:0] popcount(input logic [10:0] v);
    popcount = 4'd0;
    for (int i = 0; i < 11; i++) begin
      popcount = popcount + {3'd0, v[i]};
    end
  endfunction

  logic [7:0]  cnt_q [11];
  logic [7:0]  cnt_d [11];
  logic [10:0] deb_q, deb_d;
  logic [10:0] deb_prev_q;
  logic [3:0]  target_q, target_d;
  state_t      state_q, state_d;
  logic [11:0] half_period_q, half_period_d;
  logic        load_q, load_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic [3:0]  active_count_q;
  logic        conflict_q;

  logic [10:0] rise_w, fall_w;
  logic        target_fell_w;

  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < 11; k++) begin
      cnt_d[k] = 8'd0;
      if (keys[k] != deb_q[k]) begin
        if (cnt_q[k] + 8'd1 == c_db_limit) deb_d[k] = keys[k];
        else                               cnt_d[k] = cnt_q[k] + 8'd1;
      end
    end
  end

  assign rise_w        = deb_q & ~deb_prev_q;
  assign fall_w        = ~deb_q & deb_prev_q;
  // Shift by 15 (no target) yields zero, so no range guard is needed.
  assign target_fell_w = |(fall_w & (11'd1 << target_q));

  always_comb begin
    target_d = target_q;
    if (|rise_w)            target_d = lowest_set(rise_w);
    else if (target_fell_w) target_d = lowest_set(deb_q);
  end

  always_comb begin
    state_d       = state_q;
    half_period_d = half_period_q;
    note_idx_d    = note_idx_q;
    load_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Hold off one cycle if a mute was just loaded, keeping load single-cycle.
        if (target_q != c_none && !load_q) begin
          load_d        = 1'b1;
          note_idx_d    = target_q;
          half_period_d = half_of(target_q);
          state_d       = S_PLAY;
        end
      end
      S_PLAY: begin
        if (target_q != note_idx_q) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (target_q == note_idx_q) begin
          state_d = S_PLAY;
        end else if (gen_ready) begin
          load_d        = 1'b1;
          note_idx_d    = target_q;
          half_period_d = half_of(target_q);
          state_d       = (target_q == c_none) ? S_IDLE : S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 11; k++) cnt_q[k] <= 8'd0;
      deb_q          <= 11'd0;
      deb_prev_q     <= 11'd0;
      target_q       <= c_none;
      state_q        <= S_IDLE;
      half_period_q  <= 12'd0;
      load_q         <= 1'b0;
      note_idx_q     <= c_none;
      active_count_q <= 4'd0;
      conflict_q     <= 1'b0;
    end else begin
      for (int k = 0; k < 11; k++) cnt_q[k] <= cnt_d[k];
      deb_q          <= deb_d;
      deb_prev_q     <= deb_q;
      target_q       <= target_d;
      state_q        <= state_d;
      half_period_q  <= half_period_d;
      load_q         <= load_d;
      note_idx_q     <= note_idx_d;
      active_count_q <= popcount(deb_q);
      conflict_q     <= (popcount(deb_q) > 4'd1);
    end
  end

  assign half_period  = half_period_q;
  assign load         = load_q;
  assign note_idx     = note_idx_q;
  assign active_count = active_count_q;
  assign conflict     = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_scheduler
// Function : Directed test-plan scenarios plus random key/boundary traffic,
//            all checked cycle by cycle against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_note_scheduler;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] keys;
  logic        gen_ready;
  logic [11:0] half_period;
  logic        load;
  logic [3:0]  note_idx;
  logic [3:0]  active_count;
  logic        conflict;

  note_scheduler #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .keys         (keys),
    .gen_ready    (gen_ready),
    .half_period  (half_period),
    .load         (load),
    .note_idx     (note_idx),
    .active_count (active_count),
    .conflict     (conflict)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_loads = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: levels, run lengths and note choices as plain integers.
  int          hp_tab [11] = '{2025, 2145, 2273, 2408, 2551, 2703, 2864, 3034, 3214, 3405, 3608};
  logic [10:0] m_deb, m_prev;
  int          m_run [11];
  int          m_target, m_sound, m_cnt;
  bit          m_wait, m_load, m_conf;

  function automatic int lowest(input logic [10:0] v);
    for (int i = 0; i < 11; i++) if (v[i]) return i;
    return 15;
  endfunction

  task automatic model_step(input logic [10:0] raw, input logic gr, input logic r);
    logic [10:0] rise, fall;
    int nt, ns;
    bit nw, nl;
    if (r) begin
      m_deb = '0; m_prev = '0;
      for (int k = 0; k < 11; k++) m_run[k] = 0;
      m_target = 15; m_sound = 15; m_cnt = 0;
      m_wait = 0; m_load = 0; m_conf = 0;
      return;
    end
    ns = m_sound; nw = m_wait; nl = 0;
    if (m_sound == 15) begin
      if (m_target != 15 && !m_load) begin ns = m_target; nl = 1; end
    end else if (!m_wait) begin
      nw = (m_target != m_sound);
    end else if (m_target == m_sound) begin
      nw = 0;
    end else if (gr) begin
      ns = m_target; nl = 1; nw = 0;
    end
    rise = m_deb & ~m_prev;
    fall = m_prev & ~m_deb;
    nt = m_target;
    if (rise != 0) nt = lowest(rise);
    else if (m_target != 15 && fall[m_target]) nt = lowest(m_deb);
    m_cnt  = $countones(m_deb);
    m_conf = (m_cnt > 1);
    m_prev = m_deb;
    for (int k = 0; k < 11; k++) begin
      if (raw[k] == m_deb[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] == DB) begin m_deb[k] = raw[k]; m_run[k] = 0; end
      end
    end
    m_target = nt; m_sound = ns; m_wait = nw; m_load = nl;
  endtask

  function automatic logic [21:0] model_out();
    logic [11:0] hp;
    hp = (m_sound == 15) ? 12'd0 : 12'(hp_tab[m_sound]);
    return {hp, m_load, 4'(m_sound), 4'(m_cnt), m_conf};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(keys, gen_ready, rst);
    #1;
    if (load) n_loads++;
    check_eq("cycle_outputs", {10'd0, half_period, load, note_idx, active_count, conflict},
             {10'd0, model_out()});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_gr();
    gen_ready = 1'b1;
    tick();
    gen_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int len;

  initial begin
    rst = 1'b1; keys = '0; gen_ready = 1'b0;
    do_reset();
    check_eq("reset_state", {10'd0, half_period, load, note_idx, active_count, conflict},
             {10'd0, 12'd0, 1'b0, 4'd15, 4'd0, 1'b0});

    // Single key from idle, then a short glitch
    keys = 11'b1 << 2;
    run(5);
    check_eq("single_no_early_load", load, 0);
    tick();
    check_eq("single_load", load, 1);
    check_eq("single_hp", half_period, 2273);
    check_eq("single_note", note_idx, 2);
    n_loads = 0;
    keys = (11'b1 << 2) | (11'b1 << 5);
    run(3);
    keys = 11'b1 << 2;
    run(10);
    check_eq("glitch_note", note_idx, 2);
    check_eq("glitch_count", active_count, 1);
    check_eq("glitch_loads", n_loads, 0);

    // Last-pressed wins, then fallback
    do_reset();
    keys = 11'b1 << 4; run(8);
    keys = (11'b1 << 4) | (11'b1 << 9); run(8);
    check_eq("lpw_wait_note", note_idx, 4);
    pulse_gr();
    check_eq("lpw_load", load, 1);
    check_eq("lpw_hp", half_period, 3405);
    check_eq("lpw_conflict", conflict, 1);
    check_eq("lpw_count", active_count, 2);
    keys = 11'b1 << 4; run(8);
    pulse_gr();
    check_eq("fallback_hp", half_period, 2551);
    check_eq("fallback_conflict", conflict, 0);

    // Simultaneous press
    do_reset();
    keys = (11'b1 << 7) | (11'b1 << 3); run(6);
    check_eq("simul_note", note_idx, 3);
    check_eq("simul_hp", half_period, 2408);

    // Rapid changes 0 -> 1 -> 10 before a boundary
    do_reset();
    keys = 11'b1; run(8);
    n_loads = 0;
    keys = 11'b1 << 1; run(8);
    keys = 11'b1 << 10; run(8);
    pulse_gr();
    check_eq("rapid_hp", half_period, 3608);
    check_eq("rapid_loads", n_loads, 1);

    // 0 -> 1 -> 0 before a boundary
    do_reset();
    keys = 11'b1; run(8);
    n_loads = 0;
    keys = 11'b1 << 1; run(8);
    keys = 11'b1; run(8);
    pulse_gr();
    check_eq("bounce_loads", n_loads, 0);
    check_eq("bounce_hp", half_period, 2025);

    // Release all, then a new press loads without a boundary
    do_reset();
    keys = 11'b1 << 4; run(8);
    keys = '0; run(8);
    pulse_gr();
    check_eq("mute_load", load, 1);
    check_eq("mute_hp", half_period, 0);
    check_eq("mute_note", note_idx, 15);
    keys = 11'b1 << 1; run(5);
    check_eq("repress_early", load, 0);
    tick();
    check_eq("repress_load", load, 1);
    check_eq("repress_hp", half_period, 2145);

    // Reset mid-note while pending
    do_reset();
    keys = 11'b1 << 4; run(8);
    keys = 11'b1 << 6; run(8);
    do_reset();
    check_eq("midreset_state", {10'd0, half_period, load, note_idx, active_count, conflict},
             {10'd0, 12'd0, 1'b0, 4'd15, 4'd0, 1'b0});
    run(5);
    check_eq("midreset_early", load, 0);
    tick();
    check_eq("midreset_load", load, 1);
    check_eq("midreset_hp", half_period, 2864);

    // Random traffic: key flips of random duration, sparse boundaries, rare resets
    for (int ph = 0; ph < 400; ph++) begin
      len = $urandom_range(1, 12);
      keys = keys ^ (11'b1 << $urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) keys = keys ^ (11'b1 << $urandom_range(0, 10));
      if ($urandom_range(0, 9) == 0) keys = '0;
      for (int c = 0; c < len; c++) begin
        gen_ready = ($urandom_range(0, 15) == 0);
        rst       = ($urandom_range(0, 500) == 0);
        tick();
      end
    end
    gen_ready = 1'b0; rst = 1'b0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
